// File: rtl/test_status_device_pkg.sv
// Shared constants and types for the test status device: register offsets and lifecycle states.
package test_status_pkg;

  localparam logic [1:0] OFF_TOHOST   = 2'd0;
  localparam logic [1:0] OFF_CONSOLE  = 2'd1;
  localparam logic [1:0] OFF_WDT_KICK = 2'd2;
  localparam logic [1:0] OFF_STATUS   = 2'd3;

  localparam int unsigned TOHOST_PASS = 1;

  typedef enum logic [1:0] {
    RUN,
    DONE,
    EXPIRED
  } tsd_state_t;

endpackage

// File: rtl/test_status_device_if.sv
// Core data-bus request/response bundle between the core (master) and the status device (slave).
interface test_status_device_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  bus_req_valid;
  logic                  bus_req_we;
  logic [15:0]           bus_req_addr;
  logic [DATA_WIDTH-1:0] bus_req_wdata;
  logic                  bus_req_ready;
  logic                  bus_rsp_valid;
  logic [DATA_WIDTH-1:0] bus_rsp_rdata;

  modport master (
    output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );
endinterface

// File: rtl/test_status_device_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two (>= 2).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/test_status_device.sv
// Memory-mapped end-of-test reporter with console FIFO and watchdog, on the microISA-16 data bus.
module test_status_device
  import test_status_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WDT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  test_status_device_if.slave        bus,
  output logic                       con_valid,
  output logic [7:0]                 con_data,
  input  logic                       con_ready,
  output logic                       test_done,
  output logic                       test_pass,
  output logic [14:0]                test_code,
  output logic                       wdt_expired
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WdtW = (WDT_CYCLES > 0) ? $clog2(WDT_CYCLES + 1) : 1;
  localparam logic [WdtW-1:0] WdtReload = WdtW'(WDT_CYCLES);

  typedef logic [DATA_WIDTH-5:0] cnt_ext_t;

  tsd_state_t            state_q, state_d;
  logic [WdtW-1:0]       wdt_cnt_q, wdt_cnt_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [14:0]           code_q, code_d;
  logic                  expired_q, expired_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]            offset;
  logic                  req_acc, wr_acc, rd_acc;
  logic                  tohost_wr, kick_wr, console_wr;
  logic                  fifo_full, fifo_empty;
  logic [CntW-1:0]       fifo_count;
  logic [7:0]            fifo_head;
  logic [DATA_WIDTH-1:0] status;
  logic                  unused_addr;

  assign offset      = bus.bus_req_addr[2:1];
  assign unused_addr = ^{bus.bus_req_addr[15:3], bus.bus_req_addr[0]};

  // Only a console write into a full FIFO stalls; everything else is accepted at once.
  assign bus.bus_req_ready = !(bus.bus_req_we && (offset == OFF_CONSOLE) && fifo_full);

  assign req_acc    = bus.bus_req_valid && bus.bus_req_ready;
  assign wr_acc     = req_acc && bus.bus_req_we;
  assign rd_acc     = req_acc && !bus.bus_req_we;
  assign tohost_wr  = wr_acc && (offset == OFF_TOHOST) && (bus.bus_req_wdata != '0);
  assign kick_wr    = wr_acc && (offset == OFF_WDT_KICK);
  assign console_wr = wr_acc && (offset == OFF_CONSOLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (console_wr),
    .wdata_i (bus.bus_req_wdata[7:0]),
    .pop_i   (con_valid && con_ready),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign con_valid = !fifo_empty;
  assign con_data  = fifo_empty ? 8'h00 : fifo_head;

  assign status = {cnt_ext_t'(fifo_count), expired_q, pass_q, done_q, fifo_full};

  always_comb begin
    state_d     = state_q;
    wdt_cnt_d   = wdt_cnt_q;
    done_d      = done_q;
    pass_d      = pass_q;
    code_d      = code_q;
    expired_d   = expired_q;
    rsp_valid_d = rd_acc;
    rsp_rdata_d = (rd_acc && (offset == OFF_STATUS)) ? status : '0;

    // Priority in RUN: TOHOST beats a kick, a kick beats expiry.
    case (state_q)
      RUN: begin
        if (tohost_wr) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (bus.bus_req_wdata == DATA_WIDTH'(TOHOST_PASS));
          code_d  = pass_d ? 15'd0 : bus.bus_req_wdata[15:1];
        end else if (kick_wr) begin
          wdt_cnt_d = WdtReload;
        end else if (WDT_CYCLES != 0) begin
          if (wdt_cnt_q == '0) begin
            state_d   = EXPIRED;
            expired_d = 1'b1;
          end else begin
            wdt_cnt_d = wdt_cnt_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wdt_cnt_q   <= WdtReload;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      code_q      <= '0;
      expired_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wdt_cnt_q   <= wdt_cnt_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      code_q      <= code_d;
      expired_q   <= expired_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.bus_rsp_valid = rsp_valid_q;
  assign bus.bus_rsp_rdata = rsp_rdata_q;
  assign test_done         = done_q;
  assign test_pass         = pass_q;
  assign test_code         = code_q;
  assign wdt_expired       = expired_q;

endmodule
